// File: rtl/fp_to_twos.sv
// rtl/fp_to_twos.sv - iterative compact-float {S,E,F} to two's-complement decoder
// One left shift per clock while the exponent count drains, then negate on the way out.
module fp_to_twos #(
  parameter int E_W   = 3,
  parameter int F_W   = 4,
  parameter int OUT_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [E_W+F_W:0]   fp_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   twos_out
);

  typedef enum logic [1:0] {IDLE, SHIFT, OUT} state_t;

  state_t             r_state, w_state_nxt;
  logic               r_sign, w_sign_nxt;
  logic [E_W-1:0]     r_cnt, w_cnt_nxt;
  logic [OUT_W-1:0]   r_mag, w_mag_nxt;
  logic [OUT_W-1:0]   r_twos, w_twos_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sign  <= 1'b0;
      r_cnt   <= '0;
      r_mag   <= '0;
      r_twos  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sign  <= w_sign_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mag   <= w_mag_nxt;
      r_twos  <= w_twos_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sign_nxt  = r_sign;
    w_cnt_nxt   = r_cnt;
    w_mag_nxt   = r_mag;
    w_twos_nxt  = r_twos;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_sign_nxt  = fp_in[E_W+F_W];
          w_cnt_nxt   = fp_in[F_W +: E_W];
          w_mag_nxt   = {{(OUT_W-F_W){1'b0}}, fp_in[F_W-1:0]};
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (r_cnt != '0) begin
          w_mag_nxt = r_mag << 1;
          w_cnt_nxt = r_cnt - E_W'(1);
        end else begin
          // ~0+1 wraps to 0, so negative zero never produces the sign-only pattern
          w_twos_nxt  = r_sign ? (~r_mag + OUT_W'(1)) : r_mag;
          w_state_nxt = OUT;
        end
      end
      OUT: begin
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == OUT);
  assign twos_out  = r_twos;

endmodule

// File: tb/tb_fp_to_twos.sv
// tb/tb_fp_to_twos.sv - self-checking bench for fp_to_twos
module tb_fp_to_twos;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  fp_in = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] twos_out;

  int total = 0;
  int bad   = 0;

  fp_to_twos #(.E_W(3), .F_W(4), .OUT_W(12)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .fp_in(fp_in), .out_valid(out_valid), .out_ready(out_ready),
    .twos_out(twos_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  code;
    logic [11:0] exp;
    int          lat;
    int          delay;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] ref_val(input logic [7:0] c);
    int v;
    v = int'(c[3:0]) * (1 << int'(c[6:4]));
    if (c[7]) v = -v;
    return v[11:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_conv(input logic [7:0] code, input int delay,
                          input logic [11:0] exp, input int exp_lat);
    int lat;
    logic [11:0] held;
    chk("idle_in_ready", in_ready, 1'b1);
    fp_in     = code;
    in_valid  = 1'b1;
    out_ready = (delay == 0);
    tick();
    in_valid = 1'b0;
    fp_in    = 8'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      chk("busy_in_ready", in_ready, 1'b0);
      tick();
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("result", twos_out, exp);
    held = twos_out;
    for (int i = 0; i < delay; i++) begin
      in_valid = 1'($urandom);
      fp_in    = 8'($urandom);
      tick();
      chk("hold_out_valid", out_valid, 1'b1);
      chk("hold_twos_out", twos_out, held);
      chk("hold_in_ready", in_ready, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("post_hs_out_valid", out_valid, 1'b0);
    chk("post_hs_in_ready", in_ready, 1'b1);
    chk("post_hs_twos_kept", twos_out, held);
    out_ready = 1'b0;
  endtask

  initial begin
    int seen;
    logic [7:0] c;

    vecs[0] = '{8'h3A, 12'h050, 4, 0};
    vecs[1] = '{8'hFF, 12'h880, 8, 0};
    vecs[2] = '{8'h7F, 12'h780, 8, 2};
    vecs[3] = '{8'h05, 12'h005, 1, 0};
    vecs[4] = '{8'h80, 12'h000, 1, 1};
    vecs[5] = '{8'hD0, 12'h000, 6, 0};
    vecs[6] = '{8'hA3, 12'hFF4, 3, 5};

    tick();
    tick();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_twos_out", twos_out, 12'h000);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++)
      run_conv(vecs[i].code, vecs[i].delay, vecs[i].exp, vecs[i].lat);

    // asynchronous reset while a result is being held
    fp_in = 8'hFF; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    chk("pre_rst_held", twos_out, 12'h880);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_in_ready", in_ready, 1'b1);
    chk("async_rst_out_valid", out_valid, 1'b0);
    chk("async_rst_twos_out", twos_out, 12'h000);
    tick();
    rst = 1'b0;

    // reset mid-shift discards the code
    fp_in = 8'h61; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen++;
      tick();
    end
    chk("discarded_no_out_valid", seen, 0);
    out_ready = 1'b0;
    run_conv(8'h13, 0, 12'h006, 2);

    for (int i = 0; i < 200; i++) begin
      c = 8'($urandom);
      run_conv(c, int'($urandom_range(0, 3)), ref_val(c), int'(c[6:4]) + 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
